dmem_wait_responder: RTL

- Data-memory responder for the pipeline's MEM stage. It sits on the far side of the mem_read/mem_write/address/write_data interface that the pipeline drives.
- Accesses an internal word array after a configurable number of wait states.
- Holds the pipeline with stall until the access completes, and returns read data with a one-cycle ready pulse.
- Replaces the zero-latency data memory, so the hazard/stall path can be exercised against realistic memory timing.

---
 rtl/mips_mem_pkg.sv | 20 ++
 rtl/dmem_word_array.sv | 25 ++
 rtl/dmem_wait_responder.sv | 125 ++++++++++++
 3 files changed

// File: rtl/mips_mem_pkg.sv
// Shared types and helpers for the wait-state data-memory responder.
package mips_mem_pkg;

  localparam int WORD_W = 32;
  localparam int LAT_W  = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/dmem_word_array.sv
// Single-port word RAM: synchronous write, registered read, contents not reset.
module dmem_word_array
  import mips_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int IDX_W       = clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem_q [DEPTH_WORDS];
  logic [WORD_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[idx] <= wdata;
    rdata_q <= mem_q[idx];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_wait_responder.sv
// MEM-stage data memory with LATENCY wait states, stall hold and one-cycle ready pulse.
//   state | meaning
//   IDLE  | no access in flight; a request is latched and stalls combinationally
//   WAIT  | counting down wait states, pipeline held
//   DONE  | ready pulse, read data presented, write commits on exit edge
module dmem_wait_responder
  import mips_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [WORD_W-1:0] address,
  input  logic [WORD_W-1:0] write_data,
  output logic [WORD_W-1:0] read_data,
  output logic              ready,
  output logic              stall,
  output logic              misalign_err
);

  localparam int               IDX_W    = clog2(DEPTH_WORDS);
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(LATENCY - 1);

  state_e            state_q, state_d;
  logic [LAT_W-1:0]  cnt_q, cnt_d;
  logic              wr_q, wr_d;
  logic              mis_q, mis_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic [WORD_W-1:0] rhold_q, rhold_d;

  logic              ram_we;
  logic [IDX_W-1:0]  ram_idx;
  logic [WORD_W-1:0] ram_rdata;
  logic              req;
  logic              unused_addr_hi;

  assign req            = mem_read | mem_write;
  assign unused_addr_hi = ^address[WORD_W-1:IDX_W+2];

  dmem_word_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_array (
    .clk  (clk),
    .we   (ram_we),
    .idx  (ram_idx),
    .wdata(wdata_q),
    .rdata(ram_rdata)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    wr_d         = wr_q;
    mis_d        = mis_q;
    idx_d        = idx_q;
    wdata_d      = wdata_q;
    rhold_d      = rhold_q;
    stall        = 1'b0;
    ready        = 1'b0;
    misalign_err = 1'b0;
    read_data    = rhold_q;
    ram_we       = 1'b0;
    ram_idx      = idx_q;

    case (state_q)
      IDLE: begin
        // With LATENCY=1 the RAM read must use the live address to be ready in DONE.
        ram_idx = address[IDX_W+1:2];
        stall   = req;
        if (req) begin
          wr_d    = mem_write;
          mis_d   = (address[1:0] != 2'b00);
          idx_d   = address[IDX_W+1:2];
          wdata_d = write_data;
          cnt_d   = LAT_LOAD;
          state_d = (LATENCY > 1) ? WAIT : DONE;
        end
      end
      WAIT: begin
        stall = 1'b1;
        cnt_d = cnt_q - LAT_W'(1);
        // Counter reaches zero on the edge that enters DONE.
        if (cnt_q == LAT_W'(1)) state_d = DONE;
      end
      DONE: begin
        ready        = 1'b1;
        misalign_err = mis_q;
        if (mis_q)      read_data = '0;
        else if (!wr_q) read_data = ram_rdata;
        rhold_d = read_data;
        ram_we  = wr_q & ~mis_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (!rst) stall = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      mis_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rhold_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      mis_q   <= mis_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rhold_q <= rhold_d;
    end
  end

endmodule
